// File: rtl/vga_pkg.sv
// Shared definitions for the picture-memory arbiter: scan-state codes,
// default pixel width and the picture-size helper.
package vga_pkg;

  localparam int DW_RGB = 24;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int pic_size(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/vmem_wfifo.sv
// Posted-write FIFO holding {addr,data} entries. Power-of-two depth;
// the level counter is one bit wider than the pointers so "full" is explicit.
module vmem_wfifo #(
  parameter int FDEPTH = 4,
  parameter int W      = 8,
  localparam int PW    = $clog2(FDEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [LW-1:0] o_level,
  output logic          o_empty,
  output logic          o_full
);

  logic [W-1:0]  r_mem [FDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(FDEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and level, so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Picture-memory port scheduler: the display reader owns the port whenever
// pic_en is high; posted host writes drain from a small FIFO on idle cycles.
module vmem_arbiter
  import vga_pkg::*;
#(
  parameter int PICH    = 100,
  parameter int PICV    = 100,
  parameter int PICSIZE = pic_size(PICH, PICV),
  parameter int AW      = $clog2(PICH) + $clog2(PICV),
  parameter int DW      = DW_RGB,
  parameter int FDEPTH  = 4,
  localparam int LW     = $clog2(FDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pic_en,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [LW-1:0] fifo_level,
  output logic          err_addr,
  output logic          err_overrun
);

  localparam logic [AW-1:0] LAST_PIX  = AW'(PICSIZE - 1);
  localparam logic [AW:0]   PICSIZE_W = (AW + 1)'(PICSIZE);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_err_addr;
  logic             r_err_ovr;

  logic             w_xfer;
  logic             w_bad;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW+DW-1:0] w_head;

  vmem_wfifo #(
    .FDEPTH (FDEPTH),
    .W      (AW + DW)
  ) u_wfifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_wdata ({host_addr, host_wdata}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (fifo_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Out-of-range writes still complete the handshake but are discarded.
  assign host_ready = rst && !w_full;
  assign w_xfer     = host_req && host_ready;
  assign w_bad      = ({1'b0, host_addr} >= PICSIZE_W);
  assign w_push     = w_xfer && !w_bad;
  assign w_pop      = rst && !pic_en && !w_empty;

  assign err_addr    = r_err_addr;
  assign err_overrun = r_err_ovr;

  // NOTE: every output gets a default before the branches so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst && pic_en) begin
      mem_re = 1'b1;
      if (r_state == ST_SCAN && !frame_start) mem_addr = r_cnt;
    end else if (w_pop) begin
      mem_we    = 1'b1;
      mem_addr  = w_head[DW +: AW];
      mem_wdata = w_head[DW-1:0];
    end
  end

  // A frame_start read is pixel 0, so the counter resumes at 1 after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_err_addr <= 1'b0;
      r_err_ovr  <= 1'b0;
    end else begin
      r_err_addr <= w_xfer && w_bad;

      if (frame_start) begin
        r_state <= ST_SCAN;
        r_cnt   <= pic_en ? AW'(1) : '0;
      end else if (r_state == ST_SCAN && pic_en) begin
        if (r_cnt == LAST_PIX) begin
          r_state <= ST_DONE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + AW'(1);
        end
      end

      if (frame_start)                         r_err_ovr <= 1'b0;
      else if (r_state == ST_DONE && pic_en)   r_err_ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter on a 4x4 picture with a 5-bit address so
// out-of-range host writes are expressible.
module tb_vmem_arbiter;

  localparam int PICH = 4;
  localparam int PICV = 4;
  localparam int PS   = PICH * PICV;
  localparam int AW   = 5;
  localparam int DW   = 24;
  localparam int FD   = 4;
  localparam int LW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          pic_en = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [LW-1:0] fifo_level;
  logic          err_addr;
  logic          err_overrun;

  vmem_arbiter #(
    .PICH(PICH), .PICV(PICV), .AW(AW), .DW(DW), .FDEPTH(FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pic_en      (pic_en),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .fifo_level  (fifo_level),
    .err_addr    (err_addr),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ready;
    logic [LW-1:0] level;
    logic          erra;
    logic          ovr;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  exp_t exp_q[$];
  ent_t m_fifo[$];
  int   m_pos;   // -1: no frame yet; 0..PS-1: pixels read so far; PS: picture done
  bit   m_ovr;
  bit   m_erra;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_fifo.delete();
    m_ovr  = 1'b0;
    m_erra = 1'b0;
  endtask

  // Drives one cycle of inputs, queues the expected outputs, advances the model.
  task automatic step(input bit fs, input bit pe, input bit hr,
                      input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    exp_t e;
    ent_t ent;
    bit   ready;
    bit   bad;
    frame_start = fs;
    pic_en      = pe;
    host_req    = hr;
    host_addr   = ha;
    host_wdata  = hd;

    ready   = m_fifo.size() < FD;
    e.re    = pe;
    e.we    = !pe && m_fifo.size() > 0;
    e.ready = ready;
    e.level = LW'(m_fifo.size());
    e.erra  = m_erra;
    e.ovr   = m_ovr;
    e.addr  = '0;
    e.data  = '0;
    if (pe) begin
      if (!fs && m_pos >= 0 && m_pos < PS) e.addr = AW'(m_pos);
    end else if (e.we) begin
      e.addr = m_fifo[0].a;
      e.data = m_fifo[0].d;
    end
    exp_q.push_back(e);

    if (fs) begin
      m_ovr = 1'b0;
      m_pos = pe ? 1 : 0;
    end else if (pe) begin
      if (m_pos == PS)     m_ovr = 1'b1;
      else if (m_pos >= 0) m_pos++;
    end
    bad    = int'(ha) >= PS;
    m_erra = hr && ready && bad;
    if (e.we) void'(m_fifo.pop_front());
    if (hr && ready && !bad) begin
      ent.a = ha;
      ent.d = hd;
      m_fifo.push_back(ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pe);
    step(1'b0, pe, 1'b0, '0, '0);
  endtask

  // Monitor: compares against the oldest queued expectation away from the edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_re",      32'(mem_re),      32'(e.re));
        check("mem_we",      32'(mem_we),      32'(e.we));
        check("mem_addr",    32'(mem_addr),    32'(e.addr));
        check("mem_wdata",   32'(mem_wdata),   32'(e.data));
        check("host_ready",  32'(host_ready),  32'(e.ready));
        check("fifo_level",  32'(fifo_level),  32'(e.level));
        check("err_addr",    32'(err_addr),    32'(e.erra));
        check("err_overrun", 32'(err_overrun), 32'(e.ovr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    pic_en = 1'b1;
    #12;
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_mem_re",     32'(mem_re),     32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_err_ovr",    32'(err_overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset, then a read in IDLE (address 0, no advance).
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Full frame, one overrun read, then frame_start clears the flag.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < PS; i++) idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(1'b0);

    // Four posted writes while the display holds the port, one refused.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, AW'(3 + 2 * i), DW'(10 + i));
    step(1'b0, 1'b1, 1'b1, AW'(11), DW'(14));
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Interleaved reads and drains with two queued writes.
    step(1'b0, 1'b1, 1'b1, AW'(1), DW'('h11));
    step(1'b0, 1'b1, 1'b1, AW'(2), DW'('h22));
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);

    // Address boundary: 15 is the last legal pixel, 16 and 31 are dropped.
    step(1'b0, 1'b1, 1'b1, AW'(16), DW'('h99));
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, AW'(15), DW'('h55));
    step(1'b0, 1'b1, 1'b1, AW'(31), DW'('h66));
    idle(1'b0);
    idle(1'b0);

    // frame_start mid-scan restarts at pixel 0, then 1.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) idle(1'b1);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 19)), DW'($urandom));

    // Reset in the middle of a drain with three writes queued.
    for (int i = 0; i < 6; i++) idle(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, AW'(4 + i), DW'('h30 + i));
    pic_en   = 1'b0;
    host_req = 1'b0;
    #2;
    check("pre_rst_mem_we",   32'(mem_we),   32'd1);
    check("pre_rst_mem_addr", 32'(mem_addr), 32'd4);
    rst = 1'b0;
    #1;
    check("async_mem_we",     32'(mem_we),     32'd0);
    check("async_mem_addr",   32'(mem_addr),   32'd0);
    check("async_mem_wdata",  32'(mem_wdata),  32'd0);
    check("async_fifo_level", 32'(fifo_level), 32'd0);
    check("async_host_ready", 32'(host_ready), 32'd0);
    pic_en = 1'b1;
    #1;
    check("async_mem_re",     32'(mem_re),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
